// File: rtl/conv2d_stride_pad_pkg.sv
// Shared types, geometry helpers and output saturation for the strided/padded convolution layer.
package conv2d_stride_pad_pkg;

    localparam int FEATURE_W        = 16;
    localparam int WEIGHT_W         = 16;
    localparam int SUM_W            = 32;
    localparam int weight_frac_bits = 8;

    typedef logic signed [FEATURE_W-1:0] feature_type;
    typedef logic signed [WEIGHT_W-1:0]  weight_type;
    typedef logic signed [SUM_W-1:0]     sum_type;

    localparam sum_type FEATURE_MAX = sum_type'((1 << (FEATURE_W - 1)) - 1);
    localparam sum_type FEATURE_MIN = -sum_type'(1 << (FEATURE_W - 1));

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        PROC,
        SEND,
        DONE
    } conv_st_type;

    // Output map size along one axis: 'same' rounds up, 'valid' only keeps full windows.
    function automatic int out_dim(input int n, input int f, input int stride, input int same);
        return (same != 0) ? (n + stride - 1) / stride : (n - f) / stride + 1;
    endfunction

    function automatic int pad_of(input int f, input int same);
        return (same != 0) ? f / 2 : 0;
    endfunction

    // Counter/address width that never collapses to zero bits.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic feature_type sat_feature(input sum_type s);
        sum_type t;
        t = s;
        if (s > FEATURE_MAX)
            t = FEATURE_MAX;
        else if (s < FEATURE_MIN)
            t = FEATURE_MIN;
        return feature_type'(t);
    endfunction

endpackage

// File: rtl/feature_if.sv
// Single-lane feature stream with valid/ready handshake.
interface feature_if;
    import conv2d_stride_pad_pkg::*;

    logic             valid;
    logic             ready;
    feature_type [0:0] features;

    modport source (output valid, output features, input ready);
    modport sink   (input valid, input features, output ready);
endinterface

// File: rtl/conv2d_stride_pad_mac.sv
// Window multiply-accumulate: per-row product sums registered, then the window sum registered (latency 2).
module conv_window_mac
    import conv2d_stride_pad_pkg::*;
#(
    parameter int FILTER_HEIGHT = 5,
    parameter int FILTER_WIDTH  = 5
) (
    input  logic                                          clock,
    input  weight_type  [FILTER_HEIGHT-1:0][FILTER_WIDTH-1:0] taps_w,
    input  feature_type [FILTER_HEIGHT-1:0][FILTER_WIDTH-1:0] taps_x,
    output sum_type                                       sum
);

    sum_type [FILTER_HEIGHT-1:0] row_sum_d;
    sum_type [FILTER_HEIGHT-1:0] row_sum_q;
    sum_type                     win_d;

    // Each product is rescaled before summing so the tree stays in output units.
    always_comb begin
        for (int r = 0; r < FILTER_HEIGHT; r++) begin
            row_sum_d[r] = '0;
            for (int c = 0; c < FILTER_WIDTH; c++)
                row_sum_d[r] = row_sum_d[r]
                    + ((sum_type'($signed(taps_w[r][c])) * sum_type'($signed(taps_x[r][c])))
                       >>> weight_frac_bits);
        end
    end

    always_comb begin
        win_d = '0;
        for (int r = 0; r < FILTER_HEIGHT; r++)
            win_d = win_d + row_sum_q[r];
    end

    always_ff @(posedge clock) begin
        row_sum_q <= row_sum_d;
        sum       <= win_d;
    end

endmodule

// File: rtl/conv2d_stride_pad.sv
// Strided, optionally zero-padded 2-D convolution with runtime weights, ReLU and saturating output.
module conv2d_stride_pad
    import conv2d_stride_pad_pkg::*;
#(
    parameter int IMAGE_HEIGHT  = 28,
    parameter int IMAGE_WIDTH   = 28,
    parameter int FILTER_HEIGHT = 5,
    parameter int FILTER_WIDTH  = 5,
    parameter int input_images  = 1,
    parameter int output_images = 20,
    parameter int STRIDE        = 1,
    parameter int PAD_SAME      = 1,
    parameter int RELU_EN       = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    feature_if.sink          features_in,
    feature_if.source        features_out,
    input  logic             wgt_we,
    input  logic             wgt_sel,
    input  logic [$clog2(output_images*input_images*FILTER_HEIGHT*FILTER_WIDTH):0] wgt_addr,
    input  weight_type       wgt_data,
    output logic             busy,
    output logic             wgt_err,
    output logic             frame_done
);

    localparam int OUT_H  = out_dim(IMAGE_HEIGHT, FILTER_HEIGHT, STRIDE, PAD_SAME);
    localparam int OUT_W  = out_dim(IMAGE_WIDTH, FILTER_WIDTH, STRIDE, PAD_SAME);
    localparam int PAD_R  = pad_of(FILTER_HEIGHT, PAD_SAME);
    localparam int PAD_C  = pad_of(FILTER_WIDTH, PAD_SAME);
    localparam int IMG_N  = input_images * IMAGE_HEIGHT * IMAGE_WIDTH;
    localparam int W_N    = output_images * input_images * FILTER_HEIGHT * FILTER_WIDTH;
    localparam int O_N    = OUT_H * OUT_W;
    localparam int IAW    = cw(IMG_N);
    localparam int WAW    = cw(W_N);
    localparam int OAW    = cw(O_N);
    localparam int OCW    = cw(output_images);
    localparam int ICW    = cw(input_images);
    localparam int RW     = cw(OUT_H);
    localparam int CW     = cw(OUT_W);
    localparam int STAGES = 2;

    feature_type img_mem  [IMG_N];
    weight_type  wgt_mem  [W_N];
    weight_type  bias_mem [output_images];
    sum_type     obuf     [O_N];

    conv_st_type     state;
    logic [IAW-1:0]  in_idx;
    logic [OCW-1:0]  oc;
    logic [ICW-1:0]  ic;
    logic [RW-1:0]   orow;
    logic [CW-1:0]   ocol;
    logic [OAW-1:0]  pix_idx;
    logic [OAW-1:0]  out_idx;
    logic            issue_done;
    logic            in_ready;
    logic            out_valid;
    feature_type     out_data;

    logic                       issue;
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:1]            vld_q;
    logic [STAGES:1][OAW-1:0]   idx_q;
    logic [STAGES:1]            first_q;

    weight_type  [FILTER_HEIGHT-1:0][FILTER_WIDTH-1:0] taps_w;
    feature_type [FILTER_HEIGHT-1:0][FILTER_WIDTH-1:0] taps_x;
    sum_type     win_sum;
    sum_type     acc;
    sum_type     acc_d;

    assign features_in.ready       = in_ready;
    assign features_out.valid      = out_valid;
    assign features_out.features[0] = out_data;

    assign issue    = (state == PROC) && !issue_done;
    assign vld_pipe = {vld_q, issue};

    function automatic feature_type post(input sum_type s);
        sum_type t;
        t = s;
        if (RELU_EN != 0 && s < 0)
            t = '0;
        return sat_feature(t);
    endfunction

    // Gather the current window; taps that fall outside the image read as zero.
    always_comb begin
        int pr, pc, pi, wi;
        pr = 0; pc = 0; pi = 0; wi = 0;
        for (int r = 0; r < FILTER_HEIGHT; r++) begin
            for (int c = 0; c < FILTER_WIDTH; c++) begin
                pr = int'(orow) * STRIDE + r - PAD_R;
                pc = int'(ocol) * STRIDE + c - PAD_C;
                pi = (int'(ic) * IMAGE_HEIGHT + pr) * IMAGE_WIDTH + pc;
                wi = ((int'(oc) * input_images + int'(ic)) * FILTER_HEIGHT + r) * FILTER_WIDTH + c;
                taps_x[r][c] = '0;
                if (pr >= 0 && pr < IMAGE_HEIGHT && pc >= 0 && pc < IMAGE_WIDTH)
                    taps_x[r][c] = img_mem[pi[IAW-1:0]];
                taps_w[r][c] = wgt_mem[wi[WAW-1:0]];
            end
        end
    end

    conv_window_mac #(
        .FILTER_HEIGHT(FILTER_HEIGHT),
        .FILTER_WIDTH (FILTER_WIDTH)
    ) u_mac (
        .clock (clock),
        .taps_w(taps_w),
        .taps_x(taps_x),
        .sum   (win_sum)
    );

    // ic is innermost, so channel partial sums for one pixel arrive back to back.
    assign acc_d = (first_q[STAGES] ? sum_type'(bias_mem[oc]) : acc) + win_sum;

    // Storage is deliberately outside reset: weights and buffers survive an abort.
    always_ff @(posedge clock) begin
        if (state == RECV && in_ready && features_in.valid)
            img_mem[in_idx] <= features_in.features[0];
        if (wgt_we && !busy) begin
            if (!wgt_sel && int'(wgt_addr) < W_N)
                wgt_mem[wgt_addr[WAW-1:0]] <= wgt_data;
            if (wgt_sel && int'(wgt_addr) < output_images)
                bias_mem[wgt_addr[OCW-1:0]] <= wgt_data;
        end
        if (vld_pipe[STAGES]) begin
            obuf[idx_q[STAGES]] <= acc_d;
            acc                 <= acc_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            in_idx     <= '0;
            oc         <= '0;
            ic         <= '0;
            orow       <= '0;
            ocol       <= '0;
            pix_idx    <= '0;
            out_idx    <= '0;
            issue_done <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            wgt_err    <= 1'b0;
            frame_done <= 1'b0;
            vld_q      <= '0;
            idx_q      <= '0;
            first_q    <= '0;
        end else begin
            frame_done <= 1'b0;
            vld_q      <= vld_pipe[STAGES-1:0];
            idx_q      <= {idx_q[1], pix_idx};
            first_q    <= {first_q[1], ic == '0};
            if (wgt_we && busy)
                wgt_err <= 1'b1;

            case (state)
                IDLE: begin
                    state    <= RECV;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                    in_idx   <= '0;
                end
                RECV: begin
                    if (features_in.valid && in_ready) begin
                        if (in_idx == IAW'(IMG_N - 1)) begin
                            in_ready   <= 1'b0;
                            in_idx     <= '0;
                            oc         <= '0;
                            ic         <= '0;
                            orow       <= '0;
                            ocol       <= '0;
                            pix_idx    <= '0;
                            issue_done <= 1'b0;
                            state      <= PROC;
                        end else begin
                            in_idx <= in_idx + IAW'(1);
                        end
                    end
                end
                PROC: begin
                    if (!issue_done) begin
                        if (ic == ICW'(input_images - 1)) begin
                            ic      <= '0;
                            pix_idx <= pix_idx + OAW'(1);
                            if (ocol == CW'(OUT_W - 1)) begin
                                ocol <= '0;
                                if (orow == RW'(OUT_H - 1)) begin
                                    orow       <= '0;
                                    pix_idx    <= '0;
                                    issue_done <= 1'b1;
                                end else begin
                                    orow <= orow + RW'(1);
                                end
                            end else begin
                                ocol <= ocol + CW'(1);
                            end
                        end else begin
                            ic <= ic + ICW'(1);
                        end
                    end else if (!vld_pipe[1] && !vld_pipe[2]) begin
                        out_idx   <= '0;
                        out_data  <= post(obuf[0]);
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (features_out.ready) begin
                        if (out_idx == OAW'(O_N - 1)) begin
                            out_valid <= 1'b0;
                            out_idx   <= '0;
                            if (oc == OCW'(output_images - 1)) begin
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                state      <= DONE;
                            end else begin
                                oc         <= oc + OCW'(1);
                                issue_done <= 1'b0;
                                state      <= PROC;
                            end
                        end else begin
                            out_idx  <= out_idx + OAW'(1);
                            out_data <= post(obuf[out_idx + OAW'(1)]);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
